// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus bundle.
//   imem_*   : request/grant/response handshake to instruction memory
//   if_*     : head-of-queue instruction presented to decode
//   id_ready : decode accepts the head this cycle
// master = fetch stage side, slave = memory/decode side.
interface if_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        id_ready;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output if_valid, if_pc, if_inst,
      input  id_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  if_valid, if_pc, if_inst,
      output id_ready
   );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage.
// Holds the fetch PC, issues in-order requests to instruction memory, tags
// each outstanding request with its PC, and buffers returned instructions in
// a small queue for decode. A jump/branch redirect reloads the PC, empties the
// queue and arms a kill counter that swallows responses still in flight.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   npc              : next PC from the next-PC selector
//   j_flush, b_flush : jump / branch redirect
//   pc4              : pc + 4 to the next-PC selector
//   bus              : imem handshake and decode-side queue head (master)
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] npc,
   input  logic        j_flush,
   input  logic        b_flush,
   output logic [31:0] pc4,
   if_stage_if.master  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   kill_q, kill_d;
   logic [31:0]     tag_q   [DEPTH];
   logic [PW-1:0]   tag_wr_q, tag_rd_q;
   logic [31:0]     fpc_q   [DEPTH];
   logic [31:0]     finst_q [DEPTH];
   logic [PW-1:0]   f_wr_q, f_rd_q;

   logic            flush, pop, issue, rsp, push;
   logic [CW:0]     inflight;

   assign flush = j_flush | b_flush;
   assign pop   = bus.if_valid & bus.id_ready & ~flush;
   // Slots committed after this cycle's pop: the pop frees one entry early so
   // a 1-cycle memory can sustain one instruction per cycle.
   assign inflight = {1'b0, out_cnt_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
   assign issue = bus.imem_req & bus.imem_gnt;
   // A response with nothing outstanding is a protocol error; ignore it.
   assign rsp   = bus.imem_rvalid & (out_cnt_q != '0);
   // Responses are dropped while stale ones are being drained, and any
   // push coinciding with a redirect is lost with the cleared queue.
   assign push  = rsp & (kill_q == '0) & ~flush;

   assign pc4           = pc_q + 32'd4;
   assign bus.imem_addr = pc_q;
   assign bus.if_valid  = (cnt_q != '0);
   assign bus.if_pc     = fpc_q[f_rd_q];
   assign bus.if_inst   = finst_q[f_rd_q];

   assign pc_d      = (flush | issue) ? npc : pc_q;
   assign out_cnt_d = out_cnt_q + CW'(issue) - CW'(rsp);
   assign cnt_d     = flush ? '0 : cnt_q + CW'(push) - CW'(pop);

   always_comb begin
      kill_d = kill_q;
      if (flush)
         kill_d = out_cnt_q - CW'(rsp);
      else if (rsp && kill_q != '0)
         kill_d = kill_q - CW'(1);
   end

   always_comb begin
      state_d      = state_q;
      bus.imem_req = 1'b0;
      case (state_q)
         IDLE:  state_d = RUN;
         RUN:   bus.imem_req = ~flush & (inflight < (CW+1)'(DEPTH));
         DRAIN: if (kill_d == '0) state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (flush)
         state_d = (kill_d != '0) ? DRAIN : RUN;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q      <= RESET_PC;
         out_cnt_q <= '0;
         cnt_q     <= '0;
         kill_q    <= '0;
         tag_wr_q  <= '0;
         tag_rd_q  <= '0;
         f_wr_q    <= '0;
         f_rd_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i]   <= '0;
            fpc_q[i]   <= '0;
            finst_q[i] <= '0;
         end
      end else begin
         pc_q      <= pc_d;
         out_cnt_q <= out_cnt_d;
         cnt_q     <= cnt_d;
         kill_q    <= kill_d;
         // Tag FIFO survives a redirect: killed responses still pop their tag.
         if (issue) begin
            tag_q[tag_wr_q] <= pc_q;
            tag_wr_q        <= tag_wr_q + PW'(1);
         end
         if (rsp)
            tag_rd_q <= tag_rd_q + PW'(1);
         if (flush) begin
            f_wr_q <= '0;
            f_rd_q <= '0;
         end else begin
            if (push) begin
               fpc_q[f_wr_q]   <= tag_q[tag_rd_q];
               finst_q[f_wr_q] <= bus.imem_rdata;
               f_wr_q          <= f_wr_q + PW'(1);
            end
            if (pop)
               f_rd_q <= f_rd_q + PW'(1);
         end
      end
   end
endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
   localparam logic [31:0] KEY = 32'hCAFE_0000;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] npc, pc4, npc_ovr;
   logic        j_flush, b_flush, use_ovr;

   if_stage_if bus ();

   if_stage #(.RESET_PC(32'h0000_0100)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .npc    (npc),
      .j_flush(j_flush),
      .b_flush(b_flush),
      .pc4    (pc4),
      .bus    (bus)
   );

   // Next-PC selector stand-in: sequential unless the test overrides it.
   assign npc = use_ovr ? npc_ovr : pc4;

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Memory model: fixed latency, in-order responses, data = addr ^ KEY.
   typedef struct { logic [31:0] a; int due; } pend_t;
   pend_t q[$];
   int    cyc;
   int    lat;
   bit    gnt_en;
   bit    spur;

   typedef struct {
      bit          rst;
      bit          rdy;
      bit          gnt;
      bit          exp_req;
      logic [31:0] exp_addr;
      bit          exp_vld;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tv[23];

   function automatic vec_t mk(bit rst, bit rdy, bit gnt, bit req, logic [31:0] addr,
                               bit vld, logic [31:0] pc);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.gnt = gnt; v.exp_req = req;
      v.exp_addr = addr; v.exp_vld = vld; v.exp_pc = pc;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rstn    = 1'b0;
      j_flush = 1'b0;
      b_flush = 1'b0;
      use_ovr = 1'b0;
      npc_ovr = '0;
      spur    = 1'b0;
      gnt_en  = 1'b1;
      lat     = 1;
      q.delete();
      bus.id_ready    = 1'b1;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      @(posedge clk);
      #1;
      chk("rst pc4",      pc4,            32'h104);
      chk("rst imem_req", bus.imem_req,   0);
      chk("rst addr",     bus.imem_addr,  32'h100);
      chk("rst if_valid", bus.if_valid,   0);
      chk("rst if_pc",    bus.if_pc,      0);
      chk("rst if_inst",  bus.if_inst,    0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      cyc  = 0;
   endtask

   // Called at posedge+1 with test inputs already set; leaves time at posedge+3.
   task automatic begin_cycle();
      bus.imem_gnt = gnt_en;
      if (q.size() > 0 && q[0].due <= cyc) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = q[0].a ^ KEY;
      end else if (spur) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = 32'hFFFF_FFFF;
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = '0;
      end
      #2;
   endtask

   task automatic end_cycle();
      if (q.size() > 0 && q[0].due <= cyc)
         void'(q.pop_front());
      if (bus.imem_req && bus.imem_gnt)
         q.push_back('{bus.imem_addr, cyc + lat});
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      begin_cycle();
      end_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int  k;
      bit  seen_req, seen_vld;
      int  req_k, vld_k;
      logic [31:0] req_a;

      // Streaming, 1-cycle memory, decode always ready.
      tv[0]  = mk(1, 1, 1, 0, 32'h100, 0, 0);
      tv[1]  = mk(0, 1, 1, 1, 32'h100, 0, 0);
      tv[2]  = mk(0, 1, 1, 1, 32'h104, 0, 0);
      tv[3]  = mk(0, 1, 1, 1, 32'h108, 1, 32'h100);
      tv[4]  = mk(0, 1, 1, 1, 32'h10C, 1, 32'h104);
      tv[5]  = mk(0, 1, 1, 1, 32'h110, 1, 32'h108);
      // Decode stalled for 6 cycles: queue fills with two entries, then drains.
      tv[6]  = mk(1, 0, 1, 0, 32'h100, 0, 0);
      tv[7]  = mk(0, 0, 1, 1, 32'h100, 0, 0);
      tv[8]  = mk(0, 0, 1, 1, 32'h104, 0, 0);
      tv[9]  = mk(0, 0, 1, 0, 32'h108, 1, 32'h100);
      tv[10] = mk(0, 0, 1, 0, 32'h108, 1, 32'h100);
      tv[11] = mk(0, 0, 1, 0, 32'h108, 1, 32'h100);
      tv[12] = mk(0, 1, 1, 1, 32'h108, 1, 32'h100);
      tv[13] = mk(0, 1, 1, 1, 32'h10C, 1, 32'h104);
      tv[14] = mk(0, 1, 1, 1, 32'h110, 1, 32'h108);
      tv[15] = mk(0, 1, 1, 1, 32'h114, 1, 32'h10C);
      // Grant withheld for 3 cycles: address and pc4 hold.
      tv[16] = mk(1, 1, 0, 0, 32'h100, 0, 0);
      tv[17] = mk(0, 1, 0, 1, 32'h100, 0, 0);
      tv[18] = mk(0, 1, 0, 1, 32'h100, 0, 0);
      tv[19] = mk(0, 1, 0, 1, 32'h100, 0, 0);
      tv[20] = mk(0, 1, 1, 1, 32'h100, 0, 0);
      tv[21] = mk(0, 1, 1, 1, 32'h104, 0, 0);
      tv[22] = mk(0, 1, 1, 1, 32'h108, 1, 32'h100);

      for (int i = 0; i < 23; i++) begin
         if (tv[i].rst) do_reset();
         bus.id_ready = tv[i].rdy;
         gnt_en       = tv[i].gnt;
         begin_cycle();
         chk($sformatf("vec%0d imem_req", i), bus.imem_req,  tv[i].exp_req);
         chk($sformatf("vec%0d addr", i),     bus.imem_addr, tv[i].exp_addr);
         chk($sformatf("vec%0d pc4", i),      pc4,           tv[i].exp_addr + 32'd4);
         chk($sformatf("vec%0d if_valid", i), bus.if_valid,  tv[i].exp_vld);
         if (tv[i].exp_vld) begin
            chk($sformatf("vec%0d if_pc", i),   bus.if_pc,   tv[i].exp_pc);
            chk($sformatf("vec%0d if_inst", i), bus.if_inst, tv[i].exp_pc ^ KEY);
         end
         end_cycle();
      end

      // Branch redirect with two requests outstanding, latency 3.
      do_reset();
      lat = 3;
      repeat (3) step();
      b_flush = 1'b1; use_ovr = 1'b1; npc_ovr = 32'h200;
      begin_cycle();
      chk("bflush req", bus.imem_req, 0);
      end_cycle();
      b_flush = 1'b0; use_ovr = 1'b0;
      seen_req = 0; seen_vld = 0; req_k = 0; vld_k = 0; req_a = '0;
      k = 1;
      while (!seen_vld && k <= 20) begin
         begin_cycle();
         if (bus.imem_req && !seen_req) begin
            seen_req = 1; req_k = k; req_a = bus.imem_addr;
         end
         if (bus.if_valid) begin
            seen_vld = 1; vld_k = k;
            chk("bflush first if_pc", bus.if_pc, 32'h200);
            chk("bflush first inst",  bus.if_inst, 32'h200 ^ KEY);
         end
         end_cycle();
         k++;
      end
      chk("bflush seen valid", seen_vld, 1);
      chk("bflush req addr",   req_a, 32'h200);
      chk("bflush req cycle",  req_k, 3);
      chk("bflush vld cycle",  vld_k, 7);

      // Jump redirect coinciding with a response, cnt=1 and out_cnt=1.
      do_reset();
      bus.id_ready = 1'b0;
      repeat (3) step();
      j_flush = 1'b1; use_ovr = 1'b1; npc_ovr = 32'h300;
      begin_cycle();
      chk("jflush rvalid setup", bus.imem_rvalid, 1);
      chk("jflush head setup",   bus.if_valid, 1);
      chk("jflush req",          bus.imem_req, 0);
      end_cycle();
      j_flush = 1'b0; use_ovr = 1'b0; bus.id_ready = 1'b1;
      begin_cycle();
      chk("jflush+1 if_valid", bus.if_valid, 0);
      chk("jflush+1 req",      bus.imem_req, 1);
      chk("jflush+1 addr",     bus.imem_addr, 32'h300);
      end_cycle();
      begin_cycle();
      chk("jflush+2 if_valid", bus.if_valid, 0);
      chk("jflush+2 addr",     bus.imem_addr, 32'h304);
      end_cycle();
      begin_cycle();
      chk("jflush+3 if_valid", bus.if_valid, 1);
      chk("jflush+3 if_pc",    bus.if_pc, 32'h300);
      end_cycle();

      // PC wrap at the top of the address space.
      do_reset();
      j_flush = 1'b1; use_ovr = 1'b1; npc_ovr = 32'hFFFF_FFFC;
      begin_cycle();
      chk("wrap idle req", bus.imem_req, 0);
      end_cycle();
      j_flush = 1'b0; use_ovr = 1'b0;
      begin_cycle();
      chk("wrap addr",  bus.imem_addr, 32'hFFFF_FFFC);
      chk("wrap pc4",   pc4, 32'h0);
      chk("wrap req",   bus.imem_req, 1);
      end_cycle();
      begin_cycle();
      chk("wrap next addr", bus.imem_addr, 32'h0);
      chk("wrap next pc4",  pc4, 32'h4);
      end_cycle();
      begin_cycle();
      chk("wrap if_pc",   bus.if_pc, 32'hFFFF_FFFC);
      chk("wrap if_inst", bus.if_inst, 32'hFFFF_FFFC ^ KEY);
      end_cycle();
      begin_cycle();
      chk("wrap if_pc2",  bus.if_pc, 32'h0);
      end_cycle();

      // Spurious response with nothing outstanding is ignored.
      do_reset();
      spur = 1'b1;
      step();
      spur = 1'b0;
      begin_cycle();
      chk("spur if_valid", bus.if_valid, 0);
      chk("spur req",      bus.imem_req, 1);
      end_cycle();
      begin_cycle();
      chk("spur if_valid2", bus.if_valid, 0);
      end_cycle();
      begin_cycle();
      chk("spur if_pc", bus.if_pc, 32'h100);
      chk("spur if_valid3", bus.if_valid, 1);
      end_cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
